// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port
// and the data port. One access at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Build option: define ARB_RR_EN for round-robin arbitration on contended
// cycles; without it the data port has fixed priority.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] count;
  logic       win_dm;
  logic       win_we;
  logic       win_misaligned;
  logic       pick_dm;
  logic       dm_aligned;
  logic       capture;

  assign dm_aligned = (dm_addr[1:0] == 2'b00);

`ifdef ARB_RR_EN
  logic rr_dm_first;

  // Winner selection: the pointer decides only when both ports ask at once
  always_comb begin
    pick_dm = dm_req;
    if (dm_req && if_req) pick_dm = rr_dm_first;
  end

  // Pointer toggles after every contended grant, starting data-first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_dm_first <= 1'b1;
    else if (state == IDLE && dm_req && if_req)
      rr_dm_first <= ~rr_dm_first;
  end
`else
  // Winner selection: data port always wins a contended cycle
  always_comb begin
    pick_dm = dm_req;
  end
`endif

  // Memory data is sampled at the end of ISSUE (single-cycle latency) or on the last WAIT cycle
  always_comb begin
    capture = 1'b0;
    case (state)
      ISSUE:   capture = (MEM_LAT == 1) && !(win_dm && win_misaligned);
      WAIT:    capture = (count == 4'd1);
      default: capture = 1'b0;
    endcase
  end

  // Access sequencer with registered grant, strobe, response and busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= 4'd0;
      win_dm         <= 1'b0;
      win_we         <= 1'b0;
      win_misaligned <= 1'b0;
      if_gnt         <= 1'b0;
      if_valid       <= 1'b0;
      if_rdata       <= '0;
      dm_gnt         <= 1'b0;
      dm_valid       <= 1'b0;
      dm_rdata       <= '0;
      dm_err         <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            win_dm <= pick_dm;
            if (pick_dm) begin
              dm_gnt         <= 1'b1;
              win_we         <= dm_we;
              win_misaligned <= !dm_aligned;
              mem_en         <= dm_aligned;
              mem_we         <= dm_we && dm_aligned;
              mem_addr       <= dm_addr;
              mem_wdata      <= dm_wdata;
            end else begin
              if_gnt         <= 1'b1;
              win_we         <= 1'b0;
              win_misaligned <= 1'b0;
              mem_en         <= 1'b1;
              mem_we         <= 1'b0;
              mem_addr       <= if_addr;
              mem_wdata      <= '0;
            end
          end
        end
        ISSUE: begin
          if_gnt <= 1'b0;
          dm_gnt <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (win_dm && win_misaligned) begin
            state    <= RESP;
            dm_valid <= 1'b1;
            dm_err   <= 1'b1;
            dm_rdata <= '0;
          end else if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            count <= LAT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          dm_err   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        if (win_dm) begin
          dm_valid <= 1'b1;
          dm_rdata <= win_we ? '0 : mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// Main instance uses MEM_LAT=2 with a latency-exact memory model; two extra
// instances (MEM_LAT=1 and MEM_LAT=15) cover the latency extremes.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

`ifdef ARB_RR_EN
  localparam logic [3:0] ORD = 4'b0101;
`else
  localparam logic [3:0] ORD = 4'b1111;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_valid, dm_gnt, dm_valid, dm_err;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        sw_req;
  logic        s1_if_gnt, s1_if_valid, s1_dm_gnt, s1_dm_valid, s1_dm_err;
  logic        s1_mem_en, s1_mem_we, s1_busy;
  logic [31:0] s1_if_rdata, s1_dm_rdata, s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
  logic        s15_if_gnt, s15_if_valid, s15_dm_gnt, s15_dm_valid, s15_dm_err;
  logic        s15_mem_en, s15_mem_we, s15_busy;
  logic [31:0] s15_if_rdata, s15_dm_rdata, s15_mem_addr, s15_mem_wdata, s15_mem_rdata;

  typedef struct {
    bit          is_dm;
    int          due;
    bit          en;
    bit          we;
    logic [31:0] addr;
  } gnt_exp_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          due;
  } rsp_exp_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t if_q[$];
  rsp_exp_t dm_q[$];
  gnt_exp_t mon_g;
  rsp_exp_t mon_r;

  // Clock and free-running cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(sw_req), .if_addr(32'h0000_0020), .if_gnt(s1_if_gnt), .if_valid(s1_if_valid),
    .if_rdata(s1_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_gnt(s1_dm_gnt), .dm_valid(s1_dm_valid), .dm_rdata(s1_dm_rdata), .dm_err(s1_dm_err),
    .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_addr(s1_mem_addr), .mem_wdata(s1_mem_wdata),
    .mem_rdata(s1_mem_rdata), .busy(s1_busy)
  );

  mem_port_arbiter #(.MEM_LAT(15), .AW(32), .DW(32)) u_lat15 (
    .clk(clk), .reset_n(reset_n),
    .if_req(sw_req), .if_addr(32'h0000_0020), .if_gnt(s15_if_gnt), .if_valid(s15_if_valid),
    .if_rdata(s15_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_gnt(s15_dm_gnt), .dm_valid(s15_dm_valid), .dm_rdata(s15_dm_rdata), .dm_err(s15_dm_err),
    .mem_en(s15_mem_en), .mem_we(s15_mem_we), .mem_addr(s15_mem_addr), .mem_wdata(s15_mem_wdata),
    .mem_rdata(s15_mem_rdata), .busy(s15_busy)
  );

  // Main memory: word 0x10 preloaded, writes stored, read data only in the sample cycle
  logic [31:0] wr_mem [0:63];
  logic [63:0] wr_flag = '0;
  logic [3:0]  lat_cnt = 4'd0;
  logic [31:0] lat_addr = 32'h0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_mem[mem_addr[7:2]]  <= mem_wdata;
      wr_flag[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_en) begin
      lat_cnt  <= 4'(LAT - 1);
      lat_addr <= mem_addr;
    end else if (lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_comb begin
    mem_rdata = BAD;
    if (lat_cnt == 4'd1) begin
      if (wr_flag[lat_addr[7:2]])
        mem_rdata = wr_mem[lat_addr[7:2]];
      else
        mem_rdata = (lat_addr == 32'h10) ? 32'h2011_0005 : 32'h0;
    end
  end

  // Latency-extreme memories: data present only in the cycle the arbiter must sample
  logic [3:0] s15_cnt = 4'd0;

  always @(posedge clk) begin
    if (s15_mem_en) s15_cnt <= 4'd14;
    else if (s15_cnt != 4'd0) s15_cnt <= s15_cnt - 4'd1;
  end

  assign s1_mem_rdata  = s1_mem_en ? 32'h1234_0001 : BAD;
  assign s15_mem_rdata = (s15_cnt == 4'd1) ? 32'h1234_000F : BAD;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event with no expectation pending (cycle %0d)", name, cyc);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_ctrl"}, 64'({if_gnt, if_valid, dm_gnt, dm_valid, dm_err, mem_en, mem_we, busy}), 64'd0);
    checkOutput({name, "_if_rdata"}, 64'(if_rdata), 64'd0);
    checkOutput({name, "_dm_rdata"}, 64'(dm_rdata), 64'd0);
    checkOutput({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a grant or response pulse is visible
  always @(negedge clk) begin
    if (reset_n) begin
      if (if_gnt || dm_gnt) begin
        checkOutput("gnt_onehot", 64'(if_gnt & dm_gnt), 64'd0);
        if (gnt_q.size() == 0) begin
          reportFail("unexpected_gnt");
        end else begin
          mon_g = gnt_q.pop_front();
          checkOutput("gnt_port_is_dm", 64'(dm_gnt), 64'(mon_g.is_dm));
          checkOutput("gnt_cycle", 64'(cyc), 64'(mon_g.due));
          checkOutput("gnt_mem_en", 64'(mem_en), 64'(mon_g.en));
          if (mon_g.en) begin
            checkOutput("gnt_mem_addr", 64'(mem_addr), 64'(mon_g.addr));
            checkOutput("gnt_mem_we", 64'(mem_we), 64'(mon_g.we));
          end
        end
      end
      if (if_valid) begin
        if (if_q.size() == 0) begin
          reportFail("unexpected_if_valid");
        end else begin
          mon_r = if_q.pop_front();
          checkOutput("if_rdata", 64'(if_rdata), 64'(mon_r.data));
          checkOutput("if_valid_cycle", 64'(cyc), 64'(mon_r.due));
        end
      end
      if (dm_valid) begin
        if (dm_q.size() == 0) begin
          reportFail("unexpected_dm_valid");
        end else begin
          mon_r = dm_q.pop_front();
          checkOutput("dm_rdata", 64'(dm_rdata), 64'(mon_r.data));
          checkOutput("dm_err", 64'(dm_err), 64'(mon_r.err));
          checkOutput("dm_valid_cycle", 64'(cyc), 64'(mon_r.due));
        end
      end else if (dm_err) begin
        reportFail("dm_err_without_valid");
      end
    end
  end

  task automatic waitDone(input string name);
    int n = 0;
    while ((gnt_q.size() != 0 || if_q.size() != 0 || dm_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (gnt_q.size() != 0 || if_q.size() != 0 || dm_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: %0d grants and %0d responses still pending", name,
               gnt_q.size(), if_q.size() + dm_q.size());
      gnt_q.delete();
      if_q.delete();
      dm_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic applyStimulus(input string name, input bit is_dm, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_data, input bit exp_err);
    @(posedge clk);
    #1;
    c0 = cyc;
    gnt_q.push_back('{is_dm, c0 + 1, !exp_err, we, addr});
    if (is_dm) dm_q.push_back('{exp_data, exp_err, exp_err ? c0 + 2 : c0 + LAT + 1});
    else       if_q.push_back('{exp_data, 1'b0, c0 + LAT + 1});
    if (is_dm) begin
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = addr;
      dm_wdata = wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    waitDone(name);
  endtask

  int v1, v15, b1, b15;
  logic [31:0] d1, d15;

  initial begin
    if_req   = 1'b0;
    if_addr  = 32'h0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    sw_req   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkReset("reset_init");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] single accesses");
    applyStimulus("fetch_0x10", 1'b0, 1'b0, 32'h10, 32'h0, 32'h2011_0005, 1'b0);
    applyStimulus("write_0x40", 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0);
    applyStimulus("read_0x40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("write_0x44", 1'b1, 1'b1, 32'h44, 32'h1234_5678, 32'h0, 1'b0);
    applyStimulus("misaligned_0x42", 1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);

    $display("[TB] reset during WAIT");
    @(posedge clk);
    #1;
    c0 = cyc;
    gnt_q.push_back('{1'b0, c0 + 1, 1'b1, 1'b0, 32'h10});
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkReset("reset_midwait");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    checkOutput("midwait_gnt_seen", 64'(gnt_q.size()), 64'd0);
    applyStimulus("fetch_after_reset", 1'b0, 1'b0, 32'h10, 32'h0, 32'h2011_0005, 1'b0);

    $display("[TB] both ports contending");
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back('{ORD[k], c0 + 1 + 4 * k, 1'b1, 1'b0, ORD[k] ? 32'h40 : 32'h10});
      if (ORD[k]) dm_q.push_back('{32'hDEAD_BEEF, 1'b0, c0 + 3 + 4 * k});
      else        if_q.push_back('{32'h2011_0005, 1'b0, c0 + 3 + 4 * k});
    end
    if_req  = 1'b1;
    if_addr = 32'h10;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h40;
    repeat (13) @(posedge clk);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    waitDone("contention");

    $display("[TB] latency sweep MEM_LAT=1 and MEM_LAT=15");
    v1  = -1;
    v15 = -1;
    b1  = 0;
    b15 = 0;
    d1  = 32'h0;
    d15 = 32'h0;
    @(posedge clk);
    #1;
    c0 = cyc;
    sw_req = 1'b1;
    @(posedge clk);
    #1;
    sw_req = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (s1_busy) b1++;
      if (s15_busy) b15++;
      if (s1_if_valid) begin
        v1 = cyc;
        d1 = s1_if_rdata;
      end
      if (s15_if_valid) begin
        v15 = cyc;
        d15 = s15_if_rdata;
      end
    end
    checkOutput("lat1_req_to_valid", 64'(v1 - c0 + 1), 64'd3);
    checkOutput("lat15_req_to_valid", 64'(v15 - c0 + 1), 64'd17);
    checkOutput("lat1_busy_cycles", 64'(b1), 64'd2);
    checkOutput("lat15_busy_cycles", 64'(b15), 64'd16);
    checkOutput("lat1_rdata", 64'(d1), 64'h1234_0001);
    checkOutput("lat15_rdata", 64'(d15), 64'h1234_000F);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
